// File: rtl/call_stack_pkg.sv
// Shared constants, width helpers and snapshot type for the call/return stack.
// Shared by call_stack, call_stack_mem and call_stack_if.
package call_stack_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_DEPTH = 8;
    localparam int SNAP_FIELD_W  = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Fields are wide enough for any practical DEPTH; users size-cast in and out.
    typedef struct packed {
        logic [SNAP_FIELD_W-1:0] tp;
        logic [SNAP_FIELD_W-1:0] count;
    } snap_t;

endpackage

// File: rtl/call_stack_if.sv
// Control/data bundle between the hazard/ID logic (master) and call_stack (slave).
interface call_stack_if
    import call_stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) ();

    logic                      push;
    logic                      pop;
    logic [WIDTH-1:0]          write_data;
    logic                      ckpt;
    logic                      restore;
    logic                      clr_err;
    logic [WIDTH-1:0]          read_data;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      empty;
    logic                      full;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output push, pop, write_data, ckpt, restore, clr_err,
        input  read_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, write_data, ckpt, restore, clr_err,
        output read_data, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/call_stack_mem.sv
// DEPTH x WIDTH entry array: one write port, one asynchronous read port,
// asynchronous active-low clear of every entry.
module call_stack_mem
    import call_stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Call/return stack with simultaneous push/pop, sticky errors and one checkpoint slot.
// Define CALL_STACK_WRAP_EN to make push-while-full overwrite the oldest entry.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    call_stack_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    tp_q, tp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    snap_t            snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] mem_rdata;
    logic             is_empty;
    logic             is_full;
    logic             ovf_set;
    logic             unf_set;

    assign top_idx  = tp_q - PW'(1);
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));

    call_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.write_data),
        .raddr_i (top_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        tp_d      = tp_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        mem_we    = 1'b0;
        mem_waddr = tp_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (bus.restore) begin
            tp_d  = PW'(snap_q.tp);
            cnt_d = CW'(snap_q.count);
        end else begin
            if (bus.ckpt) begin
                snap_d.tp    = SNAP_FIELD_W'(tp_q);
                snap_d.count = SNAP_FIELD_W'(cnt_q);
            end

            if (bus.push && bus.pop && !is_empty) begin
                // Return immediately followed by call: replace the top in place.
                mem_we    = 1'b1;
                mem_waddr = top_idx;
            end else if (bus.push) begin
                if (!is_full) begin
                    mem_we = 1'b1;
                    tp_d   = tp_q + PW'(1);
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    mem_we = 1'b1;
                    tp_d   = tp_q + PW'(1);
`endif
                end
            end else if (bus.pop) begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    tp_d  = top_idx;
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end

        ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
        unf_d = (unf_q & ~bus.clr_err) | unf_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp_q   <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            tp_q   <= tp_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.read_data = is_empty ? '0 : mem_rdata;
    assign bus.count     = cnt_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack (WIDTH=12, DEPTH=8); honours CALL_STACK_WRAP_EN.
module tb_call_stack;

`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    call_stack_if #(.WIDTH(12), .DEPTH(8)) bus ();

    call_stack #(.WIDTH(12), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given controls; outputs settle #1 after the edge.
    task automatic cyc(input logic ps, input logic pp, input logic [11:0] wd,
                       input logic ck, input logic rs, input logic ce);
        bus.push       = ps;
        bus.pop        = pp;
        bus.write_data = wd;
        bus.ckpt       = ck;
        bus.restore    = rs;
        bus.clr_err    = ce;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.ckpt    = 1'b0;
        bus.restore = 1'b0;
        bus.clr_err = 1'b0;
        $display("t=%0t push=%0b pop=%0b wd=%03h ckpt=%0b rest=%0b clr=%0b -> rd=%03h cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b",
                 $time, ps, pp, wd, ck, rs, ce, bus.read_data, bus.count,
                 bus.empty, bus.full, bus.overflow, bus.underflow);
    endtask

    task automatic push(input logic [11:0] wd);
        cyc(1'b1, 1'b0, wd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.write_data = '0;
        bus.ckpt       = 1'b0;
        bus.restore    = 1'b0;
        bus.clr_err    = 1'b0;

        // Reset state
        #3;
        check("rst_rd",    bus.read_data, 0);
        check("rst_cnt",   bus.count,     0);
        check("rst_empty", bus.empty,     1);
        check("rst_full",  bus.full,      0);
        check("rst_ovf",   bus.overflow,  0);
        check("rst_unf",   bus.underflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic push/pop
        push(12'h010);
        push(12'h020);
        push(12'h030);
        check("p3_rd",  bus.read_data, 12'h030);
        check("p3_cnt", bus.count,     3);
        pop();
        check("pop_rd",  bus.read_data, 12'h020);
        check("pop_cnt", bus.count,     2);
        pop();
        pop();
        check("drain_empty", bus.empty, 1);

        // Underflow, clear, and set-wins-over-clear
        pop();
        check("unf_cnt", bus.count,     0);
        check("unf_rd",  bus.read_data, 0);
        check("unf_set", bus.underflow, 1);
        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        check("unf_clr", bus.underflow, 0);
        cyc(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1);
        check("unf_setwins", bus.underflow, 1);
        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

        // Fill to full, then push while full
        for (int i = 1; i <= 8; i++) push(12'(i));
        check("full_flag", bus.full,      1);
        check("full_cnt",  bus.count,     8);
        check("full_ovf0", bus.overflow,  0);
        push(12'h009);
        check("ovf_set", bus.overflow,  1);
        check("ovf_cnt", bus.count,     8);
        check("ovf_rd",  bus.read_data, WRAP ? 12'h009 : 12'h008);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d", i), bus.read_data, WRAP ? 32'(9 - i) : 32'(8 - i));
            pop();
        end
        check("ovf_drain_empty", bus.empty, 1);
        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", bus.overflow, 0);

        // Simultaneous push+pop replaces the top
        push(12'h100);
        push(12'h200);
        cyc(1'b1, 1'b1, 12'h300, 1'b0, 1'b0, 1'b0);
        check("pp_rd",  bus.read_data, 12'h300);
        check("pp_cnt", bus.count,     2);
        pop();
        check("pp_pop_rd", bus.read_data, 12'h100);
        pop();
        cyc(1'b1, 1'b1, 12'h0EE, 1'b0, 1'b0, 1'b0);
        check("pp_empty_cnt", bus.count,     1);
        check("pp_empty_rd",  bus.read_data, 12'h0EE);
        check("pp_empty_unf", bus.underflow, 0);
        pop();

        // Checkpoint / restore
        push(12'h0A0);
        cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        push(12'h0B0);
        push(12'h0C0);
        check("ck_pre_cnt", bus.count, 3);
        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("rest_cnt", bus.count,     1);
        check("rest_rd",  bus.read_data, 12'h0A0);
        cyc(1'b1, 1'b0, 12'h0D0, 1'b0, 1'b1, 1'b0);
        check("rest_push_cnt", bus.count,     1);
        check("rest_push_rd",  bus.read_data, 12'h0A0);

        // Mid-stream asynchronous reset
        pop();
        pop();
        check("pre_rst_unf", bus.underflow, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 12'(12'h011 + i), (i == 2), 1'b0, 1'b0);
        end
        check("pre_rst_cnt", bus.count, 5);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_cnt",   bus.count,     0);
        check("mid_rst_empty", bus.empty,     1);
        check("mid_rst_rd",    bus.read_data, 0);
        check("mid_rst_unf",   bus.underflow, 0);
        check("mid_rst_ovf",   bus.overflow,  0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("post_rst_rest_cnt",   bus.count, 0);
        check("post_rst_rest_empty", bus.empty, 1);
        push(12'h077);
        check("post_rst_push_rd", bus.read_data, 12'h077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
